// File: rtl/ex_mem_stage.sv
// Execute stage of the 5-stage RV64 pipeline: operand forwarding, ALU, branch target,
// and the EX/MEM pipeline register with stall (hold) and flush (bubble) control.
module ex_mem_stage #(
    parameter int XLEN    = 64,
    parameter int SHAMT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    input  logic [XLEN-1:0] imm_data,
    input  logic [3:0]      funct4,
    input  logic [4:0]      rd_in,
    input  logic [1:0]      alu_op,
    input  logic            branch_in,
    input  logic            mem_read_in,
    input  logic            mem_to_reg_in,
    input  logic            mem_write_in,
    input  logic            alu_src_in,
    input  logic            reg_write_in,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] exmem_fwd_data,
    input  logic [XLEN-1:0] memwb_fwd_data,
    output logic [XLEN-1:0] EXMEM_PC_Branch,
    output logic [XLEN-1:0] EXMEM_ALU_Result,
    output logic            EXMEM_Zero,
    output logic [XLEN-1:0] EXMEM_WriteData,
    output logic [4:0]      EXMEM_rd,
    output logic            EXMEM_Branch,
    output logic            EXMEM_BranchTaken,
    output logic            EXMEM_MemRead,
    output logic            EXMEM_MemtoReg,
    output logic            EXMEM_MemWrite,
    output logic            EXMEM_RegWrite,
    output logic            EXMEM_Valid
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Maps an R-type {funct7[5], funct3} code onto an ALU operation; unknown codes add.
    function automatic logic [3:0] decode_funct(input logic [3:0] f);
        logic [3:0] sel;
        case (f)
            4'b0000: sel = ALU_ADD;
            4'b1000: sel = ALU_SUB;
            4'b0111: sel = ALU_AND;
            4'b0110: sel = ALU_OR;
            4'b0100: sel = ALU_XOR;
            4'b0001: sel = ALU_SLL;
            4'b0101: sel = ALU_SRL;
            4'b1101: sel = ALU_SRA;
            4'b0010: sel = ALU_SLT;
            4'b0011: sel = ALU_SLTU;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

    logic [3:0]         w_alu_ctrl;
    logic [XLEN-1:0]    w_op_a;
    logic [XLEN-1:0]    w_fwd_b;
    logic [XLEN-1:0]    w_op_b;
    logic [XLEN-1:0]    w_alu_result;
    logic [XLEN-1:0]    w_pc_branch;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_zero;

    logic [XLEN-1:0]    r_pc_branch;
    logic [XLEN-1:0]    r_alu_result;
    logic               r_zero;
    logic [XLEN-1:0]    r_write_data;
    logic [4:0]         r_rd;
    logic               r_branch;
    logic               r_branch_taken;
    logic               r_mem_read;
    logic               r_mem_to_reg;
    logic               r_mem_write;
    logic               r_reg_write;
    logic               r_valid;

    // ALU control; I-type ignores funct7[5] except for the SRAI/SRLI distinction.
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        case (alu_op)
            2'b00: w_alu_ctrl = ALU_ADD;
            2'b01: w_alu_ctrl = ALU_SUB;
            2'b10: w_alu_ctrl = decode_funct(funct4);
            2'b11: begin
                if (funct4[2:0] == 3'b101) begin
                    w_alu_ctrl = decode_funct(funct4);
                end else begin
                    w_alu_ctrl = decode_funct({1'b0, funct4[2:0]});
                end
            end
            default: w_alu_ctrl = ALU_ADD;
        endcase
    end

    // Forwarding muxes; select 11 falls back to the register file value.
    always_comb begin
        w_op_a = read_data1;
        case (fwd_a)
            2'b10:   w_op_a = exmem_fwd_data;
            2'b01:   w_op_a = memwb_fwd_data;
            default: w_op_a = read_data1;
        endcase
        w_fwd_b = read_data2;
        case (fwd_b)
            2'b10:   w_fwd_b = exmem_fwd_data;
            2'b01:   w_fwd_b = memwb_fwd_data;
            default: w_fwd_b = read_data2;
        endcase
        if (alu_src_in) begin
            w_op_b = imm_data;
        end else begin
            w_op_b = w_fwd_b;
        end
    end

    assign w_shamt     = w_op_b[SHAMT_W-1:0];
    assign w_pc_branch = pc_in + (imm_data << 1);
    assign w_zero      = (w_alu_result == {XLEN{1'b0}});

    // ALU datapath.
    always_comb begin
        w_alu_result = {XLEN{1'b0}};
        case (w_alu_ctrl)
            ALU_ADD:  w_alu_result = w_op_a + w_op_b;
            ALU_SUB:  w_alu_result = w_op_a - w_op_b;
            ALU_AND:  w_alu_result = w_op_a & w_op_b;
            ALU_OR:   w_alu_result = w_op_a | w_op_b;
            ALU_XOR:  w_alu_result = w_op_a ^ w_op_b;
            ALU_SLL:  w_alu_result = w_op_a << w_shamt;
            ALU_SRL:  w_alu_result = w_op_a >> w_shamt;
            ALU_SRA:  w_alu_result = $signed(w_op_a) >>> w_shamt;
            ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
            default:  w_alu_result = w_op_a + w_op_b;
        endcase
    end

    // EX/MEM register: reset, then flush (bubble), then stall (hold), else capture.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_pc_branch    <= {XLEN{1'b0}};
            r_alu_result   <= {XLEN{1'b0}};
            r_zero         <= 1'b0;
            r_write_data   <= {XLEN{1'b0}};
            r_rd           <= 5'd0;
            r_branch       <= 1'b0;
            r_branch_taken <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_mem_write    <= 1'b0;
            r_reg_write    <= 1'b0;
            r_valid        <= 1'b0;
        end else if (!stall) begin
            r_pc_branch    <= w_pc_branch;
            r_alu_result   <= w_alu_result;
            r_zero         <= w_zero;
            r_write_data   <= w_fwd_b;
            r_rd           <= rd_in;
            r_branch       <= branch_in & in_valid;
            r_branch_taken <= branch_in & w_zero & in_valid;
            r_mem_read     <= mem_read_in & in_valid;
            r_mem_to_reg   <= mem_to_reg_in & in_valid;
            r_mem_write    <= mem_write_in & in_valid;
            r_reg_write    <= reg_write_in & in_valid;
            r_valid        <= in_valid;
        end
    end

    assign EXMEM_PC_Branch   = r_pc_branch;
    assign EXMEM_ALU_Result  = r_alu_result;
    assign EXMEM_Zero        = r_zero;
    assign EXMEM_WriteData   = r_write_data;
    assign EXMEM_rd          = r_rd;
    assign EXMEM_Branch      = r_branch;
    assign EXMEM_BranchTaken = r_branch_taken;
    assign EXMEM_MemRead     = r_mem_read;
    assign EXMEM_MemtoReg    = r_mem_to_reg;
    assign EXMEM_MemWrite    = r_mem_write;
    assign EXMEM_RegWrite    = r_reg_write;
    assign EXMEM_Valid       = r_valid;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed scoreboard bench for ex_mem_stage: expectations are queued as each
// instruction is driven and compared one cycle later, #1 after the clock edge.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid;
    logic [63:0] pc_in, read_data1, read_data2, imm_data;
    logic [3:0]  funct4;
    logic [4:0]  rd_in;
    logic [1:0]  alu_op, fwd_a, fwd_b;
    logic        branch_in, mem_read_in, mem_to_reg_in, mem_write_in, alu_src_in, reg_write_in;
    logic [63:0] exmem_fwd_data, memwb_fwd_data;
    logic [63:0] EXMEM_PC_Branch, EXMEM_ALU_Result, EXMEM_WriteData;
    logic        EXMEM_Zero;
    logic [4:0]  EXMEM_rd;
    logic        EXMEM_Branch, EXMEM_BranchTaken, EXMEM_MemRead, EXMEM_MemtoReg;
    logic        EXMEM_MemWrite, EXMEM_RegWrite, EXMEM_Valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] alu;
        logic        zero;
        logic [63:0] wdata;
        logic [63:0] pcb;
        logic [4:0]  rd;
        logic [6:0]  ctrl;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ex_mem_stage #(.XLEN(64), .SHAMT_W(6)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .pc_in(pc_in), .read_data1(read_data1), .read_data2(read_data2), .imm_data(imm_data),
        .funct4(funct4), .rd_in(rd_in), .alu_op(alu_op),
        .branch_in(branch_in), .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in),
        .mem_write_in(mem_write_in), .alu_src_in(alu_src_in), .reg_write_in(reg_write_in),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .exmem_fwd_data(exmem_fwd_data), .memwb_fwd_data(memwb_fwd_data),
        .EXMEM_PC_Branch(EXMEM_PC_Branch), .EXMEM_ALU_Result(EXMEM_ALU_Result),
        .EXMEM_Zero(EXMEM_Zero), .EXMEM_WriteData(EXMEM_WriteData), .EXMEM_rd(EXMEM_rd),
        .EXMEM_Branch(EXMEM_Branch), .EXMEM_BranchTaken(EXMEM_BranchTaken),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemtoReg(EXMEM_MemtoReg),
        .EXMEM_MemWrite(EXMEM_MemWrite), .EXMEM_RegWrite(EXMEM_RegWrite),
        .EXMEM_Valid(EXMEM_Valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // ctrl = {Branch, BranchTaken, MemRead, MemtoReg, MemWrite, RegWrite, Valid}
    task automatic expect_out(input logic [63:0] alu, input logic zero, input logic [63:0] wdata,
                              input logic [63:0] pcb, input logic [4:0] rd, input logic [6:0] ctrl);
        exp_t e;
        e.alu = alu; e.zero = zero; e.wdata = wdata; e.pcb = pcb; e.rd = rd; e.ctrl = ctrl;
        exp_q.push_back(e);
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".alu"},   EXMEM_ALU_Result, e.alu);
            chk({tag, ".zero"},  {63'd0, EXMEM_Zero}, {63'd0, e.zero});
            chk({tag, ".wdata"}, EXMEM_WriteData, e.wdata);
            chk({tag, ".pcb"},   EXMEM_PC_Branch, e.pcb);
            chk({tag, ".rd"},    {59'd0, EXMEM_rd}, {59'd0, e.rd});
            chk({tag, ".ctrl"},
                {57'd0, EXMEM_Branch, EXMEM_BranchTaken, EXMEM_MemRead, EXMEM_MemtoReg,
                 EXMEM_MemWrite, EXMEM_RegWrite, EXMEM_Valid},
                {57'd0, e.ctrl});
        end
    endtask

    task automatic clear_inputs();
        in_valid = 1'b1; pc_in = 64'd0; read_data1 = 64'd0; read_data2 = 64'd0; imm_data = 64'd0;
        funct4 = 4'd0; rd_in = 5'd0; alu_op = 2'b00;
        branch_in = 1'b0; mem_read_in = 1'b0; mem_to_reg_in = 1'b0; mem_write_in = 1'b0;
        alu_src_in = 1'b0; reg_write_in = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
        exmem_fwd_data = 64'd0; memwb_fwd_data = 64'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        clear_inputs();
        // ADD 1+2 held at the inputs during reset
        read_data1 = 64'd1; read_data2 = 64'd2; rd_in = 5'd3; reg_write_in = 1'b1;
        pc_in = 64'h40; imm_data = 64'h2;
        expect_out(64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 7'b0000000); step("reset0");
        expect_out(64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 7'b0000000); step("reset1");
        reset = 1'b1;
        expect_out(64'd3, 1'b0, 64'd2, 64'h44, 5'd3, 7'b0000011); step("post_reset");

        // R-type SUB equal operands, branch taken
        clear_inputs();
        read_data1 = 64'h10; read_data2 = 64'h10; funct4 = 4'b1000; alu_op = 2'b10;
        branch_in = 1'b1; pc_in = 64'h100; imm_data = 64'h8; rd_in = 5'd5;
        expect_out(64'd0, 1'b1, 64'h10, 64'h110, 5'd5, 7'b1100001); step("sub_branch");

        // forwarding A from EX/MEM, B from MEM/WB (store data), immediate operand
        clear_inputs();
        read_data1 = 64'hAAAA; read_data2 = 64'hBBBB;
        fwd_a = 2'b10; exmem_fwd_data = 64'h5; fwd_b = 2'b01; memwb_fwd_data = 64'h3;
        alu_src_in = 1'b1; imm_data = 64'h7; pc_in = 64'h200; rd_in = 5'd7; mem_write_in = 1'b1;
        expect_out(64'hC, 1'b0, 64'h3, 64'h20E, 5'd7, 7'b0000101); step("fwd_store");

        // SRAI / SRLI
        clear_inputs();
        read_data1 = 64'h8000000000000000; alu_op = 2'b11; funct4 = 4'b1101;
        alu_src_in = 1'b1; imm_data = 64'd4; rd_in = 5'd1; reg_write_in = 1'b1;
        expect_out(64'hF800000000000000, 1'b0, 64'd0, 64'h8, 5'd1, 7'b0000011); step("srai");
        funct4 = 4'b0101;
        expect_out(64'h0800000000000000, 1'b0, 64'd0, 64'h8, 5'd1, 7'b0000011); step("srli");

        // I-type ignores funct7[5]: 1001 -> SLLI, 1000 -> ADDI
        funct4 = 4'b1001; read_data1 = 64'd1; imm_data = 64'd5;
        expect_out(64'h20, 1'b0, 64'd0, 64'hA, 5'd1, 7'b0000011); step("slli");
        funct4 = 4'b1000; read_data1 = 64'd10; imm_data = 64'd3;
        expect_out(64'd13, 1'b0, 64'd0, 64'h6, 5'd1, 7'b0000011); step("addi");

        // SLT / SLTU with -1 vs 1; fwd_a=11 must fall back to the register file
        clear_inputs();
        read_data1 = 64'hFFFFFFFFFFFFFFFF; read_data2 = 64'd1; fwd_a = 2'b11; exmem_fwd_data = 64'h5;
        alu_op = 2'b10; funct4 = 4'b0010; pc_in = 64'h10; rd_in = 5'd4; reg_write_in = 1'b1;
        expect_out(64'd1, 1'b0, 64'd1, 64'h10, 5'd4, 7'b0000011); step("slt");
        funct4 = 4'b0011;
        expect_out(64'd0, 1'b1, 64'd1, 64'h10, 5'd4, 7'b0000011); step("sltu");

        // capture an AND load-type op, then stall three cycles with changing inputs
        clear_inputs();
        read_data1 = 64'hF0F0; read_data2 = 64'hFF00; alu_op = 2'b10; funct4 = 4'b0111;
        rd_in = 5'd9; mem_read_in = 1'b1; mem_to_reg_in = 1'b1; reg_write_in = 1'b1;
        pc_in = 64'h300; imm_data = 64'h10;
        expect_out(64'hF000, 1'b0, 64'hFF00, 64'h320, 5'd9, 7'b0011011); step("and_cap");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            read_data1 = 64'h1234 + 64'(i); fwd_a = 2'b10; fwd_b = 2'b01;
            exmem_fwd_data = 64'h99 + 64'(i); memwb_fwd_data = 64'h77 + 64'(i);
            rd_in = 5'd20; alu_op = 2'b00; branch_in = 1'b1;
            expect_out(64'hF000, 1'b0, 64'hFF00, 64'h320, 5'd9, 7'b0011011); step("stall_hold");
        end
        flush = 1'b1;
        expect_out(64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 7'b0000000); step("flush_over_stall");
        stall = 1'b0; flush = 1'b0;

        // bubble: in_valid=0 masks every control bit but data is still captured
        clear_inputs();
        in_valid = 1'b0; reg_write_in = 1'b1; mem_write_in = 1'b1; branch_in = 1'b1;
        read_data1 = 64'h55; read_data2 = 64'h55; alu_op = 2'b01;
        pc_in = 64'h400; imm_data = 64'h20; rd_in = 5'd12;
        expect_out(64'd0, 1'b1, 64'h55, 64'h440, 5'd12, 7'b0000000); step("bubble");

        // reset during a stall wins, then stall holds the reset values
        clear_inputs();
        read_data1 = 64'hFF; read_data2 = 64'h0F; alu_op = 2'b10; funct4 = 4'b0100;
        rd_in = 5'd2; reg_write_in = 1'b1;
        expect_out(64'hF0, 1'b0, 64'h0F, 64'd0, 5'd2, 7'b0000011); step("xor_cap");
        stall = 1'b1; reset = 1'b0;
        expect_out(64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 7'b0000000); step("reset_in_stall");
        reset = 1'b1;
        expect_out(64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 7'b0000000); step("stall_after_reset");
        stall = 1'b0;
        expect_out(64'hF0, 1'b0, 64'h0F, 64'd0, 5'd2, 7'b0000011); step("resume");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
